// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared definitions for the AXI address FIFO and burst address generator:
// entry field layout, burst encodings and generator FSM states.
package axi_burst_addr_gen_pkg;

    // Entry layout, LSB first: prot, cache, lock, burst, size, len, addr, id
    localparam int PROT_LSB  = 0;
    localparam int PROT_W    = 3;
    localparam int CACHE_LSB = 3;
    localparam int CACHE_W   = 4;
    localparam int LOCK_LSB  = 7;
    localparam int LOCK_W    = 2;
    localparam int BURST_LSB = 9;
    localparam int BURST_W   = 2;
    localparam int SIZE_LSB  = 11;
    localparam int SIZE_W    = 2;
    localparam int LEN_LSB   = 13;
    localparam int LEN_W     = 4;
    localparam int ADDR_LSB  = 17;
    localparam int ADDR_W    = 32;
    localparam int ID_LSB    = 49;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    function automatic logic burst_legal(
        input logic [1:0] burst,
        input logic [3:0] len
    );
        logic ok;
        ok = 1'b0;
        unique case (burst)
            BURST_FIXED: ok = 1'b1;
            BURST_INCR:  ok = 1'b1;
            BURST_WRAP:  ok = (len == 4'd1) || (len == 4'd3) ||
                              (len == 4'd7) || (len == 4'd15);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen_next.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_next_addr
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int BUSWIDTH = 32
) (
    input  logic [BUSWIDTH-1:0] i_cur,
    input  logic [1:0]          i_size,
    input  logic [3:0]          i_len,
    input  burst_e              i_burst,
    output logic [BUSWIDTH-1:0] o_next
);

    logic [BUSWIDTH-1:0] w_bytes;
    logic [BUSWIDTH-1:0] w_total;
    logic [BUSWIDTH-1:0] w_aligned;
    logic [BUSWIDTH-1:0] w_lower;
    logic [BUSWIDTH-1:0] w_inc;

    assign w_bytes   = BUSWIDTH'(1) << i_size;
    assign w_total   = (BUSWIDTH'(i_len) + BUSWIDTH'(1)) << i_size;
    assign w_aligned = i_cur & ~(w_bytes - BUSWIDTH'(1));
    // Only legal wrap lengths reach here, so the window is a power of two
    assign w_lower   = i_cur & ~(w_total - BUSWIDTH'(1));
    assign w_inc     = i_cur + w_bytes;

    always_comb begin
        o_next = i_cur;
        unique case (i_burst)
            BURST_FIXED: o_next = i_cur;
            BURST_WRAP:  o_next = (w_inc == w_lower + w_total) ? w_lower : w_inc;
            default:     o_next = w_aligned + w_bytes;
        endcase
    end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Pops address entries from the upstream FIFO and expands each into
// a sequence of per-beat byte addresses with a valid/ready handshake.
module axi_burst_addr_gen
    import axi_burst_addr_gen_pkg::*;
#(
    parameter int TAGBITS  = 2,
    parameter int BUSWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [TAGBITS+48:0]  fifo_entry,
    input  logic                 fifo_empty,
    output logic                 fifo_read_en,
    output logic                 beat_valid,
    input  logic                 beat_ready,
    output logic [BUSWIDTH-1:0]  beat_addr,
    output logic [TAGBITS-1:0]   beat_id,
    output logic                 beat_last,
    output logic [2:0]           beat_prot,
    output logic                 busy,
    output logic                 err_burst
);

    logic [TAGBITS-1:0]  w_id;
    logic [ADDR_W-1:0]   w_addr;
    logic [LEN_W-1:0]    w_len;
    logic [SIZE_W-1:0]   w_size;
    logic [BURST_W-1:0]  w_burst;
    logic [LOCK_W-1:0]   w_lock;
    logic [CACHE_W-1:0]  w_cache;
    logic [PROT_W-1:0]   w_prot;
    logic                w_legal;
    burst_e              w_mode;
    logic                w_capture;
    logic                w_accept;
    logic                w_last;
    logic [BUSWIDTH-1:0] w_next;
    logic                w_unused;

    state_e              r_state;
    logic                r_valid;
    logic                r_err;
    logic [BUSWIDTH-1:0] r_addr;
    logic [TAGBITS-1:0]  r_id;
    logic [2:0]          r_prot;
    logic [3:0]          r_len;
    logic [1:0]          r_size;
    burst_e              r_mode;
    logic [3:0]          r_cnt;
    logic [LOCK_W-1:0]   r_lock;
    logic [CACHE_W-1:0]  r_cache;

    assign w_id    = fifo_entry[ID_LSB +: TAGBITS];
    assign w_addr  = fifo_entry[ADDR_LSB +: ADDR_W];
    assign w_len   = fifo_entry[LEN_LSB +: LEN_W];
    assign w_size  = fifo_entry[SIZE_LSB +: SIZE_W];
    assign w_burst = fifo_entry[BURST_LSB +: BURST_W];
    assign w_lock  = fifo_entry[LOCK_LSB +: LOCK_W];
    assign w_cache = fifo_entry[CACHE_LSB +: CACHE_W];
    assign w_prot  = fifo_entry[PROT_LSB +: PROT_W];

    // Illegal encodings degrade to INCR rather than stalling the pipe
    assign w_legal   = burst_legal(w_burst, w_len);
    assign w_mode    = w_legal ? burst_e'(w_burst) : BURST_INCR;
    assign w_capture = rst && (r_state == ST_IDLE) && !fifo_empty;
    assign w_accept  = r_valid && beat_ready;
    assign w_last    = (r_cnt == r_len);

    // Memory attributes travel with the entry but do not affect addressing
    assign w_unused  = ^{r_lock, r_cache};

    axi_next_addr #(
        .BUSWIDTH (BUSWIDTH)
    ) u_next (
        .i_cur   (r_addr),
        .i_size  (r_size),
        .i_len   (r_len),
        .i_burst (r_mode),
        .o_next  (w_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_id    <= '0;
            r_prot  <= '0;
            r_len   <= '0;
            r_size  <= '0;
            r_mode  <= BURST_FIXED;
            r_cnt   <= '0;
            r_lock  <= '0;
            r_cache <= '0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_capture) begin
                        r_state <= ST_BURST;
                        r_valid <= 1'b1;
                        r_err   <= !w_legal;
                        r_addr  <= BUSWIDTH'(w_addr);
                        r_id    <= w_id;
                        r_prot  <= w_prot;
                        r_len   <= w_len;
                        r_size  <= w_size;
                        r_mode  <= w_mode;
                        r_cnt   <= '0;
                        r_lock  <= w_lock;
                        r_cache <= w_cache;
                    end
                end
                ST_BURST: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                        end else begin
                            r_cnt  <= r_cnt + 4'd1;
                            r_addr <= w_next;
                        end
                    end
                end
            endcase
        end
    end

    assign fifo_read_en = w_capture;
    assign beat_valid   = r_valid;
    assign busy         = r_valid;
    assign beat_addr    = r_addr;
    assign beat_id      = r_id;
    assign beat_prot    = r_prot;
    assign beat_last    = r_valid && w_last;
    assign err_burst    = r_err;

endmodule

// File: doc/axi_burst_addr_gen.md
AXI_BURST_ADDR_GEN -- requirements
Module: axi_burst_addr_gen

Interface
REQ-001 Parameter: TAGBITS, default 2, ID field width of a queued address entry.
REQ-002 Parameter: BUSWIDTH, default 32, address width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 fifo_entry  input  TAGBITS+49  head entry of upstream address FIFO, packed {id, addr[31:0], len[3:0], size[1:0], burst[1:0], lock[1:0], cache[3:0], prot[2:0]} (prot at LSB).
REQ-006 fifo_empty  input  1  upstream FIFO holds no entry.
REQ-007 fifo_read_en  output  1  pop strobe to upstream FIFO.
REQ-008 beat_valid  output  1  beat_addr/beat_id/beat_last/beat_prot are valid.
REQ-009 beat_ready  input  1  downstream accepts current beat.
REQ-010 beat_addr  output  BUSWIDTH  byte address of current beat.
REQ-011 beat_id  output  TAGBITS  ID of the active burst.
REQ-012 beat_last  output  1  current beat is final beat of burst.
REQ-013 beat_prot  output  3  prot of the active burst.
REQ-014 busy  output  1  a burst is active.
REQ-015 err_burst  output  1  one-cycle pulse: captured entry had illegal burst encoding.

Function
REQ-016 FSM states IDLE and BURST only.
REQ-017 IDLE: fifo_read_en = !fifo_empty (combinational); on that edge block captures fifo_entry fields into registers and enters BURST.
REQ-018 fifo_read_en shall be 0 in BURST; never asserted while fifo_empty=1.
REQ-019 BURST: beat_valid=1, busy=1; beat advances only on an edge with beat_valid && beat_ready.
REQ-020 Beat counter 4 bits, cleared on capture; beat_last = (counter == captured len).
REQ-021 Beat accepted with beat_last=1: return to IDLE; next entry captured no earlier than the following cycle (one bubble between bursts).
REQ-022 Beat size in bytes = 1 << size (1, 2, 4, 8).
REQ-023 FIXED (burst=2'b00): every beat_addr equals captured addr.
REQ-024 INCR (2'b01): beat 0 = addr; beat n>0 = (addr aligned down to beat size) + n*bytes, modulo 2^BUSWIDTH (wraps silently at top of address space).
REQ-025 WRAP (2'b10): total = bytes*(len+1); lower = addr aligned down to total; next = cur+bytes, replaced by lower when next == lower+total.
REQ-026 WRAP with len not in {1,3,7,15}, or burst=2'b11: burst executed as INCR and err_burst pulses on the cycle after capture.
REQ-027 beat_addr/beat_id/beat_prot/beat_last held stable while beat_valid && !beat_ready.
REQ-028 lock and cache captured but not acted on.

Reset
REQ-029 rst low: state=IDLE immediately; beat_valid=0, busy=0, beat_last=0, err_burst=0, beat_addr=0, beat_id=0, beat_prot=0, counter=0; fifo_read_en=0 while rst low.
REQ-030 rst asserted mid-burst: burst abandoned, remaining beats never issued; no entry popped until rst high and an IDLE cycle with !fifo_empty.

Structure
REQ-031 Shared package holds entry field offsets/widths, burst encodings (FIXED/INCR/WRAP), and FSM state encodings; used by this block and the address FIFO.
REQ-032 One sub-module, axi_next_addr: combinational next-address calculation from cur addr, size, len, burst.

Verification
REQ-033 INCR: entry addr=0x1000, len=3, size=2, burst=01, beat_ready=1 -> addrs 0x1000,0x1004,0x1008,0x100C, beat_last on 4th, one fifo_read_en pulse.
REQ-034 WRAP: addr=0x1038, len=3, size=2, burst=10 -> 0x1038,0x103C,0x1030,0x1034.
REQ-035 Unaligned INCR: addr=0x1003, len=2, size=2 -> 0x1003,0x1004,0x1008.
REQ-036 Backpressure: FIXED addr=0x20, len=1, beat_ready low 3 cycles -> outputs stable, then 0x20,0x20 with beat_last on second.
REQ-037 Illegal: burst=11 or WRAP len=2 -> INCR sequence plus single err_burst pulse.
REQ-038 Reset mid-burst after beat 1 of len=7 -> beat_valid=0 same cycle; after release with fifo_empty=0, next entry popped and issued from beat 0.
